axi_hsuart_regbank: RTL and testbench
=====================================

Name: axi_hsuart_regbank

Overview:
Parametrised AXI4-Lite slave register bank, the successor to the fixed 4-register S00_AXI slave in the HSUART IP. It generalises register count and data width. It adds per-register modes: read-write, read-only (hardware-driven) and write-1-to-clear status. It also adds byte strobes, decoupled AW/W acceptance, B/R backpressure and SLVERR on out-of-range addresses. It sits between the AXI interconnect and the UART core's control/status logic.

Parameters:
C_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
C_NUM_REGS, 16, number of registers; 1..256.
C_ADDR_WIDTH, 10, AXI address width; must satisfy C_ADDR_WIDTH >= clog2(C_NUM_REGS)+clog2(C_DATA_WIDTH/8).
C_RO_MASK, 0, bit r = 1 makes register r read-only (value taken from hw_in).
C_W1C_MASK, 0, bit r = 1 makes register r write-1-to-clear; RO takes priority over W1C.
C_RESET_VAL, 0, flattened C_NUM_REGS*C_DATA_WIDTH reset values for RW registers.

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; one clock; reset is synchronous and active-high
S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  C_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_DATA_WIDTH/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  OKAY=0, SLVERR=2
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  C_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  C_NUM_REGS*C_DATA_WIDTH  current register contents, flattened
hw_in  in  C_NUM_REGS*C_DATA_WIDTH  hardware values for RO registers
hw_set  in  C_NUM_REGS*C_DATA_WIDTH  per-bit set pulses for W1C registers
wr_pulse  out  C_NUM_REGS  one-cycle strobe per register on each accepted write

Behaviour:
- Reset values: all READY, BVALID, RVALID, wr_pulse and RESP outputs are 0. RW registers take C_RESET_VAL; W1C registers are 0. ARESET mid-transaction drops any pending response. Held AW/W are discarded.
- Address decode: index = addr >> clog2(C_DATA_WIDTH/8). Low address bits are ignored. If index >= C_NUM_REGS, the response is SLVERR, writes have no effect and reads return 0.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY is 1 in W_IDLE and W_HAVE_W. WREADY is 1 in W_IDLE and W_HAVE_AW.
  - AW and W can arrive in the same cycle or in either order. Each is captured once; a second AW is stalled until BVALID&BREADY.
  - The register update happens in the cycle after both are held (or after a simultaneous capture). In that same cycle BVALID=1 and wr_pulse[idx]=1 for exactly one cycle.
  - Latency: simultaneous AW+W handshake at cycle N gives BVALID at N+1.
  - BVALID holds with a stable BRESP until BREADY. There is one outstanding write.
- Write semantics per byte lane with WSTRB=1:
  - RW: byte is replaced.
  - W1C: bits written 1 are cleared.
  - RO: no change, response is OKAY, wr_pulse still fires.
- W1C hardware set: each cycle, reg |= hw_set. If hw_set and a W1C clear hit the same bit in the same cycle, set wins and the bit ends at 1.
- Read FSM states: R_IDLE, R_RESP.
  - ARREADY=1 in R_IDLE only.
  - RDATA is registered from the value at AR handshake cycle N. RVALID goes high at N+1 and holds until RREADY.
  - A read of RO returns hw_in sampled at N. A read of W1C returns the value before any same-cycle write.
- Read and write channels are independent; a read and write to the same register in the same cycle returns the old value.
- reg_out reflects register state combinationally from the flops; RO slots carry hw_in.

Decomposition:
- Package axi_hsuart_regbank_pkg holds:
  - RESP_OKAY and RESP_SLVERR constants;
  - w_state_t and r_state_t enums;
  - function apply_wstrb(old, data, strb, mode);
  - reg_mode_t enum {RW, RO, W1C}.
- One sub-module, axi_hsuart_reg_cell, holds one register's storage plus mode logic and is generated C_NUM_REGS times. The FSMs stay in the top level.

Test Plan:
- Reset then read all 16 registers with C_RESET_VAL=0 -> RDATA=0x00000000, RRESP=OKAY for each; every output is 0 during reset.
- Write 0x00000001..0x00000004 to addr 0x0,0x4,0x8,0xC, then read back -> data matches, BRESP=OKAY, and wr_pulse fires once per write on indices 0..3.
- Present W 3 cycles before AW, then the reverse order, then both simultaneously, with BREADY held low 5 cycles -> one register update per transaction, BVALID stable until BREADY, no second AWREADY while BVALID is pending.
- WSTRB=4'b0010, WDATA=0xAABBCCDD onto reg holding 0x11223344 -> reads 0x1122CC44.
- W1C reg: hw_set=0x0000000F, then write 0x00000005 in the same cycle as hw_set=0x00000001 -> read 0x0000000B (bit0 set wins, bit2 cleared).
- Write and read addr 0x40 (index 16) -> BRESP=SLVERR and RRESP=SLVERR, RDATA=0, no register changed; assert ARESET while RVALID is held -> RVALID=0 the next cycle.

Source files
------------

// File: rtl/axi_hsuart_regbank_pkg.sv
// Shared types and helpers for the HSUART AXI4-Lite register bank.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   w_state_t / r_state_t   : write / read channel FSM states
//   reg_mode_t              : per-register access mode
//   apply_wstrb()           : one byte lane of a register write
package axi_hsuart_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;
  typedef enum logic [1:0] {RW, RO, W1C} reg_mode_t;

  // New value of one byte lane after a bus write with the given strobe bit.
  function automatic logic [7:0] apply_wstrb(input logic [7:0] old,
                                             input logic [7:0] data,
                                             input logic       strb,
                                             input reg_mode_t  mode);
    logic [7:0] res;
    res = old;
    if (strb) begin
      case (mode)
        RW:      res = data;
        W1C:     res = old & ~data;
        default: res = old;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_hsuart_reg_cell.sv
// One register of the bank: storage plus mode-specific update rules.
//   clk_i, srst_i : clock, synchronous active-high reset
//   wr_en_i       : accepted bus write targets this register
//   wdata_i/wstrb_i : write data and byte strobes
//   hw_in_i       : hardware value presented when MODE is RO
//   hw_set_i      : per-bit set pulses, honoured when MODE is W1C
//   q_o           : current register value
module axi_hsuart_reg_cell
  import axi_hsuart_regbank_pkg::*;
#(
  parameter int unsigned     DW        = 32,
  parameter reg_mode_t       MODE      = RW,
  parameter logic [DW-1:0]   RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_en_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   wstrb_i,
  input  logic [DW-1:0]     hw_in_i,
  input  logic [DW-1:0]     hw_set_i,
  output logic [DW-1:0]     q_o
);

  logic [DW-1:0] q_q, q_d, wr_val;

  generate
    for (genvar gi = 0; gi < DW/8; gi++) begin : g_lane
      assign wr_val[gi*8 +: 8] = apply_wstrb(q_q[gi*8 +: 8], wdata_i[gi*8 +: 8],
                                             wstrb_i[gi], MODE);
    end
  endgenerate

  // Hardware set is OR-ed in after the bus write so a coincident set wins.
  always_comb begin
    q_d = wr_en_i ? wr_val : q_q;
    if (MODE == W1C) q_d = q_d | hw_set_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  assign q_o = (MODE == RO) ? hw_in_i : q_q;

endmodule

// File: rtl/axi_hsuart_regbank.sv
// AXI4-Lite slave register bank for the HSUART core.
//   ACLK, ARESET        : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*     : write address, data and response channels
//   S_AXI_AR*/R*        : read address and data channels
//   reg_out             : flattened register contents (RO slots show hw_in)
//   hw_in               : hardware values for RO registers
//   hw_set              : per-bit set pulses for W1C registers
//   wr_pulse            : one-cycle strobe per register on each accepted write
module axi_hsuart_regbank
  import axi_hsuart_regbank_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 16,
  parameter int unsigned C_ADDR_WIDTH = 10,
  parameter logic [255:0] C_RO_MASK   = '0,
  parameter logic [255:0] C_W1C_MASK  = '0,
  parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0] C_RESET_VAL = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] hw_in,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] hw_set,
  output logic [C_NUM_REGS-1:0]              wr_pulse
);

  localparam int unsigned BYTES    = C_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W    = C_ADDR_WIDTH - ADDR_LSB;

  // Byte-offset address bits carry no meaning for word-wide registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // ---------------- write channel ----------------
  w_state_t               w_state_q;
  logic [IDX_W-1:0]       aw_idx_q;
  logic [C_DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]       wstrb_q;
  logic                   bvalid_q;
  logic [1:0]             bresp_q;
  logic [C_NUM_REGS-1:0]  wr_pulse_q;

  logic                   aw_hs, w_hs, do_write, wr_in_range;
  logic [IDX_W-1:0]       wr_idx;
  logic [C_DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]       wr_strb;
  logic [C_NUM_REGS-1:0]  wr_en;

  assign S_AXI_AWREADY = !ARESET && (w_state_q == W_IDLE || w_state_q == W_HAVE_W);
  assign S_AXI_WREADY  = !ARESET && (w_state_q == W_IDLE || w_state_q == W_HAVE_AW);
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // The write commits on the edge where the second half arrives, so the
  // half that arrives live is taken straight from the bus.
  always_comb begin
    do_write = 1'b0;
    case (w_state_q)
      W_IDLE:    do_write = aw_hs && w_hs;
      W_HAVE_AW: do_write = w_hs;
      W_HAVE_W:  do_write = aw_hs;
      default:   do_write = 1'b0;
    endcase
  end

  assign wr_idx  = (w_state_q == W_HAVE_AW) ? aw_idx_q : S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = (w_state_q == W_HAVE_W) ? wdata_q : S_AXI_WDATA;
  assign wr_strb = (w_state_q == W_HAVE_W) ? wstrb_q : S_AXI_WSTRB;
  assign wr_in_range = 32'(wr_idx) < C_NUM_REGS;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_en;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (do_write) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) w_state_q <= W_RESP;
          else if (aw_hs)    w_state_q <= W_HAVE_AW;
          else if (w_hs)     w_state_q <= W_HAVE_W;
        end
        W_HAVE_AW: if (w_hs)  w_state_q <= W_RESP;
        W_HAVE_W:  if (aw_hs) w_state_q <= W_RESP;
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign wr_pulse     = wr_pulse_q;

  // ---------------- register cells ----------------
  logic [C_DATA_WIDTH-1:0] reg_word [C_NUM_REGS];

  generate
    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
      localparam reg_mode_t MODE = C_RO_MASK[gi] ? RO : (C_W1C_MASK[gi] ? W1C : RW);
      localparam logic [C_DATA_WIDTH-1:0] RST =
        (MODE == W1C) ? '0 : C_RESET_VAL[gi*C_DATA_WIDTH +: C_DATA_WIDTH];

      assign wr_en[gi] = do_write && (32'(wr_idx) == gi);

      axi_hsuart_reg_cell #(
        .DW        (C_DATA_WIDTH),
        .MODE      (MODE),
        .RESET_VAL (RST)
      ) u_cell (
        .clk_i    (ACLK),
        .srst_i   (ARESET),
        .wr_en_i  (wr_en[gi]),
        .wdata_i  (wr_data),
        .wstrb_i  (wr_strb),
        .hw_in_i  (hw_in[gi*C_DATA_WIDTH +: C_DATA_WIDTH]),
        .hw_set_i (hw_set[gi*C_DATA_WIDTH +: C_DATA_WIDTH]),
        .q_o      (reg_word[gi])
      );

      assign reg_out[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = reg_word[gi];
    end
  endgenerate

  // ---------------- read channel ----------------
  r_state_t                r_state_q;
  logic                    rvalid_q;
  logic [1:0]              rresp_q;
  logic [C_DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]        rd_idx;
  logic [C_DATA_WIDTH-1:0] rd_word;
  logic                    rd_in_range, ar_hs;

  assign S_AXI_ARREADY = !ARESET && (r_state_q == R_IDLE);
  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx      = S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range = 32'(rd_idx) < C_NUM_REGS;

  // Out-of-range indices match no slot and read as zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      if (32'(rd_idx) == i) rd_word = reg_word[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            r_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_axi_hsuart_regbank.sv
`timescale 1ns/1ps
module tb_axi_hsuart_regbank;
  import axi_hsuart_regbank_pkg::*;

  localparam int NR = 16;
  localparam logic [255:0] RO_MASK  = 256'h0C0;  // regs 6,7
  localparam logic [255:0] W1C_MASK = 256'h0A0;  // regs 5,7 (7 stays RO)

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [9:0]    S_AXI_AWADDR, S_AXI_ARADDR;
  logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]   S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic [NR*32-1:0] reg_out, hw_in, hw_set;
  logic [NR-1:0] wr_pulse;

  axi_hsuart_regbank #(
    .C_DATA_WIDTH(32), .C_NUM_REGS(NR), .C_ADDR_WIDTH(10),
    .C_RO_MASK(RO_MASK), .C_W1C_MASK(W1C_MASK), .C_RESET_VAL('0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_ro(input int idx);
    return idx < NR && RO_MASK[idx];
  endfunction

  function automatic bit is_w1c(input int idx);
    return idx < NR && !RO_MASK[idx] && W1C_MASK[idx];
  endfunction

  function automatic logic [31:0] exp_read(input int idx);
    if (idx >= NR) return 32'h0;
    if (is_ro(idx)) return hw_in[idx*32 +: 32];
    return model[idx];
  endfunction

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx < NR && !is_ro(idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          if (is_w1c(idx)) model[idx][b*8 +: 8] = model[idx][b*8 +: 8] & ~data[b*8 +: 8];
          else             model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
      end
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input int b_delay,
                          output logic [1:0] resp, output logic [15:0] pulse_or, output int pulse_cnt);
    bit aw_done = 0, w_done = 0, b_done = 0, stable = 1, aw_in_b = 0;
    int cyc = 0, bcyc = 0;
    logic [1:0] resp0 = 2'b11;
    pulse_or = '0; pulse_cnt = 0;
    while (!b_done && cyc < 100) begin
      @(negedge ACLK);
      if (|wr_pulse) begin pulse_or |= wr_pulse; pulse_cnt += $countones(wr_pulse); end
      S_AXI_AWADDR  = addr;
      S_AXI_AWVALID = !aw_done && cyc >= aw_delay;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_WVALID  = !w_done && cyc >= w_delay;
      if (S_AXI_BVALID) begin
        if (bcyc == 0) resp0 = S_AXI_BRESP;
        else if (S_AXI_BRESP !== resp0) stable = 0;
        if (S_AXI_AWREADY) aw_in_b = 1;
        S_AXI_BREADY = (bcyc >= b_delay);
        if (S_AXI_BREADY) b_done = 1;
        bcyc++;
      end else begin
        S_AXI_BREADY = 1'b0;
      end
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      cyc++;
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    if (|wr_pulse) begin pulse_or |= wr_pulse; pulse_cnt += $countones(wr_pulse); end
    resp = resp0;
    check("write_completed", 32'(b_done), 32'd1);
    check("bresp_stable", 32'(stable), 32'd1);
    check("awready_while_bvalid", 32'(aw_in_b), 32'd0);
  endtask

  task automatic do_read(input logic [9:0] addr, input int r_delay,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, stable = 1;
    int cyc = 0, rcyc = 0;
    data = 32'hFFFF_FFFF; resp = 2'b11;
    while (!r_done && cyc < 100) begin
      @(negedge ACLK);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = !ar_done;
      if (S_AXI_RVALID) begin
        if (rcyc == 0) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
        else if (S_AXI_RDATA !== data || S_AXI_RRESP !== resp) stable = 0;
        S_AXI_RREADY = (rcyc >= r_delay);
        if (S_AXI_RREADY) r_done = 1;
        rcyc++;
      end else begin
        S_AXI_RREADY = 1'b0;
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1;
      cyc++;
    end
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_ARVALID = 1'b0;
    check("read_completed", 32'(r_done), 32'd1);
    check("rdata_stable", 32'(stable), 32'd1);
  endtask

  task automatic pulse_set(input int idx, input logic [31:0] val);
    @(negedge ACLK);
    hw_set[idx*32 +: 32] = val;
    @(negedge ACLK);
    hw_set = '0;
    if (is_w1c(idx)) model[idx] |= val;
    $display("[TB] hw_set reg=%0d val=0x%08h", idx, val);
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    logic [15:0] por;
    int          pcnt;

    vecs[0]  = '{10'h000, 32'h0000_0001, 4'hF, 32'h0000_0001, RESP_OKAY,   16'h0001};
    vecs[1]  = '{10'h004, 32'h0000_0002, 4'hF, 32'h0000_0002, RESP_OKAY,   16'h0002};
    vecs[2]  = '{10'h008, 32'h0000_0003, 4'hF, 32'h0000_0003, RESP_OKAY,   16'h0004};
    vecs[3]  = '{10'h00C, 32'h0000_0004, 4'hF, 32'h0000_0004, RESP_OKAY,   16'h0008};
    vecs[4]  = '{10'h010, 32'h1122_3344, 4'hF, 32'h1122_3344, RESP_OKAY,   16'h0010};
    vecs[5]  = '{10'h010, 32'hAABB_CCDD, 4'h2, 32'h1122_CC44, RESP_OKAY,   16'h0010};
    vecs[6]  = '{10'h040, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, RESP_SLVERR, 16'h0000};
    vecs[7]  = '{10'h3FC, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, RESP_SLVERR, 16'h0000};
    vecs[8]  = '{10'h006, 32'h0000_0055, 4'hF, 32'h0000_0055, RESP_OKAY,   16'h0002};
    vecs[9]  = '{10'h018, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, RESP_OKAY,   16'h0040};
    vecs[10] = '{10'h01C, 32'hFFFF_FFFF, 4'hF, 32'hCAFE_F00D, RESP_OKAY,   16'h0080};

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    hw_in = '0; hw_set = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 0);
    check("rst_wready",  32'(S_AXI_WREADY), 0);
    check("rst_arready", 32'(S_AXI_ARREADY), 0);
    check("rst_bvalid",  32'(S_AXI_BVALID), 0);
    check("rst_rvalid",  32'(S_AXI_RVALID), 0);
    check("rst_bresp",   32'(S_AXI_BRESP), 0);
    check("rst_rresp",   32'(S_AXI_RRESP), 0);
    check("rst_wr_pulse", 32'(wr_pulse), 0);
    ARESET = 1'b0;

    for (int i = 0; i < NR; i++) begin
      do_read(10'(i*4), 0, rd, rr);
      $display("[TB] rd reg=%0d data=0x%08h resp=%0d", i, rd, rr);
      check("reset_rdata", rd, 32'h0);
      check("reset_rresp", 32'(rr), 32'(RESP_OKAY));
    end

    // Table-driven write/readback vectors.
    hw_in[6*32 +: 32] = 32'h1234_5678;
    hw_in[7*32 +: 32] = 32'hCAFE_F00D;
    for (int v = 0; v < 11; v++) begin
      do_write(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, 0, 0, 0, br, por, pcnt);
      model_write(int'(vecs[v].addr >> 2), vecs[v].wdata, vecs[v].wstrb);
      do_read(vecs[v].addr, 1, rd, rr);
      $display("[TB] vec %0d addr=0x%03h wr=0x%08h strb=%b bresp=%0d rd=0x%08h rresp=%0d",
               v, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, br, rd, rr);
      check("vec_bresp", 32'(br), 32'(vecs[v].exp_resp));
      check("vec_pulse", 32'(por), 32'(vecs[v].exp_pulse));
      check("vec_pulse_cnt", 32'(pcnt), (vecs[v].exp_pulse != 0) ? 32'd1 : 32'd0);
      check("vec_rdata", rd, vecs[v].exp_rdata);
      check("vec_rresp", 32'(rr), 32'(vecs[v].exp_resp));
    end
    for (int i = 0; i < NR; i++) check("reg_out_after_table", reg_out[i*32 +: 32], exp_read(i));

    // Handshake orderings with BREADY held off.
    for (int k = 0; k < 3; k++) begin
      int awd, wd;
      awd = (k == 0) ? 3 : 0;
      wd  = (k == 1) ? 3 : 0;
      do_write(10'((8 + k) * 4), 32'hA5A5_0000 + 32'(k), 4'hF, awd, wd, 5, br, por, pcnt);
      model_write(8 + k, 32'hA5A5_0000 + 32'(k), 4'hF);
      $display("[TB] order %0d aw_delay=%0d w_delay=%0d bresp=%0d pulses=%0d", k, awd, wd, br, pcnt);
      check("order_bresp", 32'(br), 32'(RESP_OKAY));
      check("order_pulse", 32'(por), 32'(1 << (8 + k)));
      check("order_pulse_cnt", 32'(pcnt), 32'd1);
      do_read(10'((8 + k) * 4), 0, rd, rr);
      check("order_rdata", rd, exp_read(8 + k));
    end

    // W1C: set pulses, then a clear coinciding with a set on bit 0.
    pulse_set(5, 32'h0000_000F);
    @(negedge ACLK);
    hw_set[5*32 +: 32] = 32'h0000_0001;
    do_write(10'h014, 32'h0000_0005, 4'hF, 0, 0, 0, br, por, pcnt);
    hw_set = '0;
    model_write(5, 32'h0000_0005, 4'hF);
    model[5] |= 32'h0000_0001;
    do_read(10'h014, 0, rd, rr);
    $display("[TB] w1c clear+set rd=0x%08h", rd);
    check("w1c_set_wins", rd, 32'h0000_000B);
    check("w1c_reg_out", reg_out[5*32 +: 32], 32'h0000_000B);
    do_write(10'h014, 32'h0000_0008, 4'hF, 0, 0, 0, br, por, pcnt);
    model_write(5, 32'h0000_0008, 4'hF);
    do_read(10'h014, 0, rd, rr);
    $display("[TB] w1c clear rd=0x%08h", rd);
    check("w1c_clear", rd, 32'h0000_0003);

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      int op, idx;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      op   = $urandom_range(0, 3);
      idx  = $urandom_range(0, NR + 1);
      addr = 10'(idx * 4 + $urandom_range(0, 3));
      if (op == 3) begin
        hw_in[6*32 +: 32] = $urandom;
        hw_in[7*32 +: 32] = $urandom;
        pulse_set(5, $urandom & 32'h0000_FFFF);
      end else if (op == 0 || op == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), br, por, pcnt);
        model_write(idx, data, strb);
        $display("[TB] rnd wr addr=0x%03h data=0x%08h strb=%b bresp=%0d", addr, data, strb, br);
        check("rnd_bresp", 32'(br), (idx < NR) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
        check("rnd_pulse", 32'(por), (idx < NR) ? 32'(1 << idx) : 32'd0);
      end else begin
        do_read(addr, $urandom_range(0, 3), rd, rr);
        $display("[TB] rnd rd addr=0x%03h data=0x%08h resp=%0d", addr, rd, rr);
        check("rnd_rdata", rd, exp_read(idx));
        check("rnd_rresp", 32'(rr), (idx < NR) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
      end
    end
    for (int i = 0; i < NR; i++) check("reg_out_after_random", reg_out[i*32 +: 32], exp_read(i));

    // Reset while a read response is being held.
    @(negedge ACLK);
    S_AXI_ARADDR = 10'h004; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid_held", 32'(S_AXI_RVALID), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    $display("[TB] reset during read rvalid=%0d", S_AXI_RVALID);
    check("rvalid_dropped", 32'(S_AXI_RVALID), 32'd0);
    ARESET = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    do_read(10'h004, 0, rd, rr);
    check("post_reset_rdata", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
